gray_to_bin_serial: RTL
=======================

GRAY_TO_BIN_SERIAL -- requirements
Module: gray_to_bin_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the Gray input word and the binary output word (WIDTH >= 2).
REQ-002 SHALL have parameter BCD_CHECK, default 1: when 1, flag results above 9; when 0, bcd_err is held at 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  gray_in carries a word to decode.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port gray_in  input  WIDTH  Gray-coded word; MSB is bit WIDTH-1.
REQ-008 SHALL have port out_valid  output  1  bin_out and bcd_err hold a completed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port bin_out  output  WIDTH  decoded binary word.
REQ-011 SHALL have port bcd_err  output  1  result exceeds 9 (BCD_CHECK=1 only).

Function
REQ-012 SHALL implement a 3-state FSM with states IDLE, SHIFT and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 In IDLE, in_valid=1 at a rising edge SHALL capture gray_in into a working register, set bit index to WIDTH-1 and enter SHIFT.
REQ-015 In SHIFT, each cycle SHALL resolve one bit, MSB first: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i]; index decrements by 1.
REQ-016 After bit 0 is resolved, the FSM SHALL load bin_out and bcd_err from the working result in the same edge and enter DONE.
REQ-017 Latency SHALL be fixed: out_valid rises exactly WIDTH clock edges after the accepting edge (4 for the default).
REQ-018 bcd_err SHALL equal (BCD_CHECK==1) AND (result > 9), registered together with bin_out.
REQ-019 In DONE, bin_out, bcd_err and out_valid SHALL stay stable until out_ready=1 at a rising edge; that edge SHALL return the FSM to IDLE.
REQ-020 The block SHALL NOT accept a new word in the same cycle that a result is consumed; in_ready rises the cycle after the DONE->IDLE transition.
REQ-021 in_valid and gray_in changes during SHIFT or DONE SHALL be ignored and SHALL NOT affect the word in progress.
REQ-022 bin_out and bcd_err SHALL retain the last completed result through IDLE and SHIFT until the next result loads.
REQ-023 An illegal or unused FSM encoding SHALL recover to IDLE on the next clock edge.

Reset
REQ-024 reset=1 SHALL immediately force, independent of clk: FSM=IDLE, index=0, working register=0, bin_out=0, bcd_err=0, out_valid=0, in_ready=0.
REQ-025 in_ready SHALL go to 1 on the first rising edge after reset is deasserted.
REQ-026 Reset asserted in SHIFT or DONE SHALL abort the word, produce no out_valid pulse, and discard any partial result.

Verification
REQ-027 Reset-release scenario: after reset, all outputs are 0; on the first edge after deassertion, in_ready=1.
REQ-028 Decode scenario: gray_in=1101 with in_valid, out_ready=1 -> out_valid exactly 4 edges later, bin_out=1001, bcd_err=0.
REQ-029 BCD-flag scenario: gray_in=1111 -> bin_out=1010, bcd_err=1; repeat with BCD_CHECK=0 -> bin_out=1010, bcd_err=0.
REQ-030 Back-pressure scenario: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with gray_in=0110 -> outputs stay unchanged and in_ready=0.
REQ-031 Mid-operation reset: pulse reset 2 cycles after accepting gray_in=1000 -> no out_valid, bin_out=0, in_ready=1 after release.
REQ-032 Exhaustive round-trip: for n=0..15, drive gray_in=n XOR (n>>1) back-to-back -> bin_out=n each time, bcd_err=(n>9), no words lost or duplicated.

Source files
------------

// File: rtl/gray_to_bin_serial.sv
// Serial Gray-to-binary decoder: one bit resolved per clock, MSB first,
// with a valid/ready handshake on both sides and an optional "above 9" flag.
module gray_to_bin_serial #(
  parameter int WIDTH     = 4,
  parameter bit BCD_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             bcd_err
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] work_q, work_d, work_res;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic             over9;

  // The working register is decoded in place: bit idx+1 already holds b[idx+1].
  always_comb begin
    work_res = work_q;
    if (idx_q != IW'(WIDTH - 1)) begin
      work_res[idx_q] = work_q[idx_q + 1'b1] ^ work_q[idx_q];
    end
  end

  generate
    if (WIDTH >= 4) begin : g_cmp
      assign over9 = (work_res > WIDTH'(9));
    end else begin : g_nocmp
      assign over9 = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    bin_d   = bin_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          accept  = 1'b1;
          work_d  = gray_in;
          idx_d   = IW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = work_res;
        if (idx_q == '0) begin
          bin_d   = work_res;
          err_d   = (BCD_CHECK == 1'b1) && over9;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered so it only rises a full cycle after entering IDLE.
    rdy_d = (state_q == IDLE) && !accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      work_q  <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == DONE);
  assign bin_out   = bin_q;
  assign bcd_err   = err_q;

endmodule
